bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Arbitrates ownership of the shared 4-bit data_bus between NREQ tri-state bus drivers: ALU buffer, fetch, RAM and input port.
- Produces registered, one-hot-or-zero output enables so that no two busDriver instances drive the bus in the same cycle.
- Inserts one dead turnaround cycle between owners and enforces round-robin fairness with a bounded hold time.

Parameters:
- NREQ, 4, number of bus requesters (2..8).
- HOLD_MAX, 8, max consecutive grant cycles while another requester waits (>=1).
- IDW, $clog2(NREQ) (min 1), width of grant_id.

Ports:
- clk  input  1  system clock, rising edge.
- Rst  input  1  asynchronous, active-high reset.
- req  input  NREQ  level request per driver; held high while the driver wants the bus.
- oe  output  NREQ  registered output enables to the busDriver instances; one-hot or all-zero.
- grant_id  output  IDW  index of the current owner; valid only while busy=1.
- busy  output  1  high while any oe bit is high.
- turnaround  output  1  high during the dead cycle between owners.

Behaviour:
- Reset: asynchronous and active-high.
  - Clears oe=0, grant_id=0, busy=0 and turnaround=0.
  - Sets state=IDLE, hold counter=0 and last-owner pointer=NREQ-1, so req[0] wins first.
- All outputs come from registers; no combinational path from req to oe.
- States:
  - IDLE: oe=0. If req!=0 at edge n, choose the winner and enter GRANT; oe[winner]=1 after edge n (1-cycle latency).
  - GRANT: oe[owner]=1, busy=1. Hold counter increments each cycle and saturates at HOLD_MAX-1. At edge n, go to TURN if either:
    - req[owner]=0, or
    - counter==HOLD_MAX-1 and any other req bit is set.
    - Otherwise stay in GRANT, even past HOLD_MAX when no one else is waiting.
  - TURN: oe=0, busy=0, turnaround=1 for exactly one cycle. At the next edge:
    - if req!=0, choose the winner and enter GRANT with the counter cleared;
    - otherwise enter IDLE.
- Winner selection: round-robin. Search starts at last_owner+1 and wraps modulo NREQ. last_owner updates on every grant.
- A preempted owner that still holds req is considered again only after all other requesters in rotation order.
- Simultaneous events:
  - Owner drops req in the same cycle its counter expires: single TURN, no double turnaround.
  - Only the owner requests after TURN: it is re-granted, and the TURN cycle still occurs.
- oe bits never overlap: at most one bit high in any cycle, and never high during TURN.
- Rst asserted mid-grant: oe drops immediately (asynchronously). After Rst deasserts, arbitration restarts from IDLE.
- req bits for indices >= NREQ do not exist. Requests that appear during TURN are evaluated at the end of TURN.

Optional Feature:
- Macro: BUS_ARB_PRIO_EN.
- Defined:
  - req[0] (instruction fetch) has absolute priority at every winner selection, overriding round-robin.
  - The hold limit does not apply to owner 0; it keeps the bus while req[0]=1.
  - Other owners are preempted via TURN within HOLD_MAX cycles of req[0] rising.
- Undefined: pure round-robin for all requesters, HOLD_MAX applies uniformly.

Test Plan:
- Reset then single request: Rst pulse, req=0001 at edge 1 -> oe=0001, grant_id=0, busy=1 from cycle 2; req=0000 -> one cycle with oe=0000, turnaround=1, then IDLE.
- Round-robin: req=1111 held continuously, HOLD_MAX=8 -> grants 0,1,2,3,0 in order, each exactly 8 cycles of oe, separated by one turnaround cycle; oe never has more than one bit set.
- Sole requester past limit: req=0100 for 20 cycles -> oe=0100 continuously for 20 cycles, no TURN.
- Early release plus a new request: owner 1 granted, req=0010→1000 in the same cycle -> oe 0010, then 0000 for one cycle, then 1000.
- Async reset mid-grant: oe=0010, Rst raised between clock edges -> oe=0000 and busy=0 immediately; after release with req=0011 -> grant to 0.
- With BUS_ARB_PRIO_EN: owner 2 granted, req[0] rises -> within 8 cycles TURN, then oe=0001 held for as long as req[0]=1 despite req=0111.

Source files
------------

// File: rtl/bus_arbiter.sv
// bus_arbiter
// Decides which tri-state driver owns the shared data bus. Output enables are
// registered and one-hot-or-zero. Every change of owner passes through one
// dead turnaround cycle. Winners are picked round-robin, and an owner's hold
// time is bounded while another requester is waiting.
//
// Optional build macro: BUS_ARB_PRIO_EN
//   Defined:   req[0] (instruction fetch) always wins selection and is never
//              preempted by the hold limit.
//   Undefined: pure round-robin, with the hold limit applied to every owner.
//
// Ports:
//   clk        in   rising-edge system clock
//   Rst        in   asynchronous active-high reset
//   req        in   [NREQ] level requests, held while a driver wants the bus
//   oe         out  [NREQ] registered output enables, one-hot or zero
//   grant_id   out  [IDW] index of the current owner (meaningful while busy)
//   busy       out  high while an oe bit is high
//   turnaround out  high during the dead cycle between owners
module bus_arbiter #(
  parameter int NREQ     = 4,
  parameter int HOLD_MAX = 8,
  parameter int IDW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            Rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] oe,
  output logic [IDW-1:0]  grant_id,
  output logic            busy,
  output logic            turnaround
);

  localparam int HW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_MAX - 1);
  localparam logic [IDW-1:0] LAST_INIT = IDW'(NREQ - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_TURN  = 2'd2;

  logic [1:0]      state_r;
  logic [1:0]      next_state_s;
  logic [HW-1:0]   hold_r;
  logic [HW-1:0]   next_hold_s;
  logic [IDW-1:0]  last_owner_r;
  logic [IDW-1:0]  next_owner_s;
  logic            others_s;
  logic            limit_s;
  logic            release_s;

  // Decode an owner index into its enable bit.
  function automatic logic [NREQ-1:0] onehot(input logic [IDW-1:0] idx);
    onehot = {{(NREQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Round-robin pick starting after 'last'. The scan runs from the farthest
  // candidate to the nearest, so the nearest requester is the one that wins.
  // 'last' itself is scanned first, so it wins only when nobody else requests.
  // That gives a preempted owner the lowest priority in the rotation.
  function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                             input logic [IDW-1:0]  last);
    logic [IDW-1:0] pick;
    int             idx;
    pick = last;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NREQ;
      if (r[idx]) begin
        pick = IDW'(idx);
      end else begin
        pick = pick;
      end
    end
`ifdef BUS_ARB_PRIO_EN
    if (r[0]) begin
      pick = {IDW{1'b0}};
    end else begin
      pick = pick;
    end
`endif
    return pick;
  endfunction

  // Next-state, owner and hold-counter decisions.
  always_comb begin
    next_state_s = state_r;
    next_owner_s = grant_id;
    next_hold_s  = hold_r;
    others_s     = |(req & ~onehot(grant_id));
    limit_s      = (hold_r == HOLD_LAST) && others_s;
`ifdef BUS_ARB_PRIO_EN
    // The fetch port keeps the bus for as long as it keeps requesting.
    limit_s      = limit_s && (grant_id != {IDW{1'b0}});
`endif
    release_s    = !req[grant_id] || limit_s;

    case (state_r)
      ST_IDLE: begin
        if (|req) begin
          next_state_s = ST_GRANT;
          next_owner_s = rr_pick(req, last_owner_r);
          next_hold_s  = {HW{1'b0}};
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (release_s) begin
          next_state_s = ST_TURN;
        end else begin
          next_state_s = ST_GRANT;
          // The counter saturates, so a lone owner may hold the bus indefinitely.
          if (hold_r != HOLD_LAST) begin
            next_hold_s = hold_r + HW'(1);
          end else begin
            next_hold_s = hold_r;
          end
        end
      end
      ST_TURN: begin
        if (|req) begin
          next_state_s = ST_GRANT;
          next_owner_s = rr_pick(req, last_owner_r);
          next_hold_s  = {HW{1'b0}};
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
        next_hold_s  = {HW{1'b0}};
      end
    endcase
  end

  // State and registered outputs. The enables come straight from flops, so
  // Rst clears them asynchronously.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state_r      <= ST_IDLE;
      hold_r       <= {HW{1'b0}};
      last_owner_r <= LAST_INIT;
      grant_id     <= {IDW{1'b0}};
      oe           <= {NREQ{1'b0}};
      busy         <= 1'b0;
      turnaround   <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      hold_r     <= next_hold_s;
      grant_id   <= next_owner_s;
      busy       <= (next_state_s == ST_GRANT);
      turnaround <= (next_state_s == ST_TURN);
      if (next_state_s == ST_GRANT) begin
        last_owner_r <= next_owner_s;
        oe           <= onehot(next_owner_s);
      end else begin
        last_owner_r <= last_owner_r;
        oe           <= {NREQ{1'b0}};
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter
// Self-checking bench for bus_arbiter with NREQ=4 and HOLD_MAX=8. Each task
// queues (req, expected outputs) items. The items are popped one clock at a
// time: req is applied before a rising edge, and outputs are compared 1 ns
// after that edge.
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       Rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] oe;
  logic [1:0] grant_id;
  logic       busy;
  logic       turnaround;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [3:0] rq;
    logic [3:0] eoe;
    logic       turn;
    logic [1:0] gid;
  } item_t;

  item_t stim_q[$];
  item_t exp_q[$];

  bus_arbiter #(.NREQ(4), .HOLD_MAX(8)) dut (
    .clk        (clk),
    .Rst        (Rst),
    .req        (req),
    .oe         (oe),
    .grant_id   (grant_id),
    .busy       (busy),
    .turnaround (turnaround)
  );

  always #5 clk = ~clk;

  // Queue n identical cycles: the req to drive, and the outputs expected after the edge.
  task automatic add(input logic [3:0] rq, input logic [3:0] eoe, input logic turn,
                     input logic [1:0] gid, input int n);
    item_t it;
    it.rq = rq; it.eoe = eoe; it.turn = turn; it.gid = gid;
    for (int i = 0; i < n; i++) stim_q.push_back(it);
  endtask

  task automatic pulse_rst();
    Rst = 1'b1;
    req = 4'b0000;
    @(posedge clk); #1;
    Rst = 1'b0;
  endtask

  task automatic test_reset();
    item_t it, e;
    Rst = 1'b1;
    req = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (oe !== 4'b0000 || busy !== 1'b0 || turnaround !== 1'b0 || grant_id !== 2'd0)
      $display("FAIL reset: oe=%b busy=%b turn=%b id=%0d, want all zero", oe, busy, turnaround, grant_id);
    else n_pass++;
    Rst = 1'b0;
    add(4'b0001, 4'b0001, 1'b0, 2'd0, 2);
    add(4'b0000, 4'b0000, 1'b1, 2'd0, 1);
    add(4'b0000, 4'b0000, 1'b0, 2'd0, 2);
    for (int c = 0; stim_q.size() > 0; c++) begin
      it = stim_q.pop_front(); req = it.rq; exp_q.push_back(it);
      @(posedge clk); #1;
      e = exp_q.pop_front(); n_checks++;
      if (oe !== e.eoe || busy !== (|e.eoe) || turnaround !== e.turn || ((|e.eoe) && grant_id !== e.gid))
        $display("FAIL single cyc%0d: oe=%b busy=%b turn=%b id=%0d, want oe=%b turn=%b id=%0d",
                 c, oe, busy, turnaround, grant_id, e.eoe, e.turn, e.gid);
      else n_pass++;
    end
  endtask

  task automatic test_round_robin();
    item_t it, e;
    logic [1:0] order [5];
    logic [3:0] one;
    order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    pulse_rst();
    for (int g = 0; g < 5; g++) begin
      one = 4'b0001 << order[g];
      add(4'b1111, one, 1'b0, order[g], 8);
      if (g < 4) add(4'b1111, 4'b0000, 1'b1, 2'd0, 1);
      else       add(4'b0000, 4'b0000, 1'b1, 2'd0, 1);
    end
    add(4'b0000, 4'b0000, 1'b0, 2'd0, 1);
    for (int c = 0; stim_q.size() > 0; c++) begin
      it = stim_q.pop_front(); req = it.rq; exp_q.push_back(it);
      @(posedge clk); #1;
      e = exp_q.pop_front(); n_checks++;
      if (oe !== e.eoe || busy !== (|e.eoe) || turnaround !== e.turn || ((|e.eoe) && grant_id !== e.gid))
        $display("FAIL round_robin cyc%0d: oe=%b busy=%b turn=%b id=%0d, want oe=%b turn=%b id=%0d",
                 c, oe, busy, turnaround, grant_id, e.eoe, e.turn, e.gid);
      else n_pass++;
    end
  endtask

  task automatic test_sole_requester();
    item_t it, e;
    add(4'b0100, 4'b0100, 1'b0, 2'd2, 20);
    add(4'b0000, 4'b0000, 1'b1, 2'd0, 1);
    add(4'b0000, 4'b0000, 1'b0, 2'd0, 1);
    for (int c = 0; stim_q.size() > 0; c++) begin
      it = stim_q.pop_front(); req = it.rq; exp_q.push_back(it);
      @(posedge clk); #1;
      e = exp_q.pop_front(); n_checks++;
      if (oe !== e.eoe || busy !== (|e.eoe) || turnaround !== e.turn || ((|e.eoe) && grant_id !== e.gid))
        $display("FAIL sole cyc%0d: oe=%b busy=%b turn=%b id=%0d, want oe=%b turn=%b id=%0d",
                 c, oe, busy, turnaround, grant_id, e.eoe, e.turn, e.gid);
      else n_pass++;
    end
  endtask

  task automatic test_release_new();
    item_t it, e;
    add(4'b0010, 4'b0010, 1'b0, 2'd1, 2);
    add(4'b1000, 4'b0000, 1'b1, 2'd0, 1);
    add(4'b1000, 4'b1000, 1'b0, 2'd3, 1);
    add(4'b0000, 4'b0000, 1'b1, 2'd0, 1);
    add(4'b0000, 4'b0000, 1'b0, 2'd0, 1);
    for (int c = 0; stim_q.size() > 0; c++) begin
      it = stim_q.pop_front(); req = it.rq; exp_q.push_back(it);
      @(posedge clk); #1;
      e = exp_q.pop_front(); n_checks++;
      if (oe !== e.eoe || busy !== (|e.eoe) || turnaround !== e.turn || ((|e.eoe) && grant_id !== e.gid))
        $display("FAIL release cyc%0d: oe=%b busy=%b turn=%b id=%0d, want oe=%b turn=%b id=%0d",
                 c, oe, busy, turnaround, grant_id, e.eoe, e.turn, e.gid);
      else n_pass++;
    end
  endtask

  // Cases covered here: owner 0 is preempted, then re-granted when it is the
  // only requester after TURN; later it drops req in the cycle its limit expires.
  task automatic test_back_to_back();
    item_t it, e;
    pulse_rst();
    add(4'b0011, 4'b0001, 1'b0, 2'd0, 8);
    add(4'b0011, 4'b0000, 1'b1, 2'd0, 1);
    add(4'b0001, 4'b0001, 1'b0, 2'd0, 8);
    add(4'b0010, 4'b0000, 1'b1, 2'd0, 1);
    add(4'b0010, 4'b0010, 1'b0, 2'd1, 1);
    add(4'b0000, 4'b0000, 1'b1, 2'd0, 1);
    add(4'b0000, 4'b0000, 1'b0, 2'd0, 1);
    for (int c = 0; stim_q.size() > 0; c++) begin
      it = stim_q.pop_front(); req = it.rq; exp_q.push_back(it);
      @(posedge clk); #1;
      e = exp_q.pop_front(); n_checks++;
      if (oe !== e.eoe || busy !== (|e.eoe) || turnaround !== e.turn || ((|e.eoe) && grant_id !== e.gid))
        $display("FAIL back_to_back cyc%0d: oe=%b busy=%b turn=%b id=%0d, want oe=%b turn=%b id=%0d",
                 c, oe, busy, turnaround, grant_id, e.eoe, e.turn, e.gid);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    item_t it, e;
    add(4'b0010, 4'b0010, 1'b0, 2'd1, 3);
    for (int c = 0; stim_q.size() > 0; c++) begin
      it = stim_q.pop_front(); req = it.rq; exp_q.push_back(it);
      @(posedge clk); #1;
      e = exp_q.pop_front(); n_checks++;
      if (oe !== e.eoe || busy !== (|e.eoe) || turnaround !== e.turn || ((|e.eoe) && grant_id !== e.gid))
        $display("FAIL async_pre cyc%0d: oe=%b busy=%b turn=%b id=%0d, want oe=%b turn=%b id=%0d",
                 c, oe, busy, turnaround, grant_id, e.eoe, e.turn, e.gid);
      else n_pass++;
    end
    // Raise Rst between clock edges; the enables must clear with no clock.
    #2;
    Rst = 1'b1;
    #1;
    n_checks++;
    if (oe !== 4'b0000 || busy !== 1'b0)
      $display("FAIL async_rst: oe=%b busy=%b, want oe=0000 busy=0", oe, busy);
    else n_pass++;
    req = 4'b0011;
    @(posedge clk); #1;
    Rst = 1'b0;
    add(4'b0011, 4'b0001, 1'b0, 2'd0, 1);
    add(4'b0000, 4'b0000, 1'b1, 2'd0, 1);
    add(4'b0000, 4'b0000, 1'b0, 2'd0, 1);
    for (int c = 0; stim_q.size() > 0; c++) begin
      it = stim_q.pop_front(); req = it.rq; exp_q.push_back(it);
      @(posedge clk); #1;
      e = exp_q.pop_front(); n_checks++;
      if (oe !== e.eoe || busy !== (|e.eoe) || turnaround !== e.turn || ((|e.eoe) && grant_id !== e.gid))
        $display("FAIL async_post cyc%0d: oe=%b busy=%b turn=%b id=%0d, want oe=%b turn=%b id=%0d",
                 c, oe, busy, turnaround, grant_id, e.eoe, e.turn, e.gid);
      else n_pass++;
    end
  endtask

`ifdef BUS_ARB_PRIO_EN
  task automatic test_prio();
    item_t it, e;
    pulse_rst();
    add(4'b0100, 4'b0100, 1'b0, 2'd2, 4);
    add(4'b0111, 4'b0100, 1'b0, 2'd2, 4);
    add(4'b0111, 4'b0000, 1'b1, 2'd0, 1);
    add(4'b0111, 4'b0001, 1'b0, 2'd0, 20);
    add(4'b0000, 4'b0000, 1'b1, 2'd0, 1);
    add(4'b0000, 4'b0000, 1'b0, 2'd0, 1);
    for (int c = 0; stim_q.size() > 0; c++) begin
      it = stim_q.pop_front(); req = it.rq; exp_q.push_back(it);
      @(posedge clk); #1;
      e = exp_q.pop_front(); n_checks++;
      if (oe !== e.eoe || busy !== (|e.eoe) || turnaround !== e.turn || ((|e.eoe) && grant_id !== e.gid))
        $display("FAIL prio cyc%0d: oe=%b busy=%b turn=%b id=%0d, want oe=%b turn=%b id=%0d",
                 c, oe, busy, turnaround, grant_id, e.eoe, e.turn, e.gid);
      else n_pass++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_sole_requester();
    test_release_new();
    test_back_to_back();
    test_async_reset();
`ifdef BUS_ARB_PRIO_EN
    test_prio();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
